cla_adder_bist: RTL and testbench
=================================

// Module: cla_adder_bist
// PURPOSE
//   Self-test engine for the WIDTH-bit carry-lookahead adder. It sits on the other
//   side of the adder's a/b/cin -> sum/cout interface.
//   - Drives every {cin,a,b} vector into the adder.
//   - Samples sum/cout after a programmable settle time.
//   - Compares against an internal reference (a+b+cin), counts mismatches and
//     captures the first failing vector.
//   Used for on-chip/bench sign-off of the combinational adder.
// PARAMETERS
//   WIDTH   4   operand width of the adder under test
//   SETTLE  1   extra wait cycles between driving a vector and sampling (0 allowed)
//   ERRW    16  width of the saturating error counter
// PORTS
//   clk        in   1        single clock, all logic on rising edge
//   rst        in   1        synchronous, active-high reset
//   start      in   1        1-cycle pulse: begin sweep (honoured in IDLE or DONE only)
//   a          out  WIDTH    operand A to adder (registered)
//   b          out  WIDTH    operand B to adder (registered)
//   cin        out  1        carry-in to adder (registered)
//   sum        in   WIDTH    adder sum result
//   cout       in   1        adder carry-out
//   busy       out  1        sweep in progress
//   done       out  1        sweep complete; held until next accepted start or rst
//   pass       out  1        valid when done: 1 iff err_count==0
//   err_count  out  ERRW     number of mismatching vectors, saturates at all-ones
//   fail_vld   out  1        a mismatch has been captured
//   fail_a     out  WIDTH    a of first mismatching vector
//   fail_b     out  WIDTH    b of first mismatching vector
//   fail_cin   out  1        cin of first mismatching vector
// BEHAVIOUR
//   Reset (rst=1 at edge, any state, including mid-sweep):
//   - state=IDLE; all outputs 0; vector counter 0.
//   Vector counter: V = {cin,a,b}, 2*WIDTH+1 bits; b is LSBs.
//   - Sweep order 0 .. 2^(2*WIDTH+1)-1, no wrap; 512 vectors for WIDTH=4.
//   FSM states and transitions:
//   - IDLE: start=1 -> DRIVE. On entry to DRIVE: V=0, err_count=0, fail_* =0,
//     busy=1, done=0, pass=0.
//   - DRIVE (1 cycle): a/b/cin already hold V. Latch expected = a+b+cin
//     (WIDTH+1 bits: {cout,sum}).
//     Next: WAIT if SETTLE>0, else CHECK.
//   - WAIT: exactly SETTLE cycles, then CHECK.
//   - CHECK (1 cycle): compare {cout,sum} to expected.
//     - Mismatch: err_count += 1 unless already all-ones.
//       If fail_vld==0, capture fail_a/fail_b/fail_cin and set fail_vld=1.
//     - If V is the last vector -> DONE.
//     - Else V+1 is loaded into a/b/cin at this edge -> DRIVE.
//   - DONE: busy=0, done=1, pass=(err_count==0). a/b/cin hold the last vector.
//     start=1 -> restart exactly as from IDLE.
//   Timing:
//   - Per-vector period = SETTLE+2 cycles.
//   - start-accept edge to done=1: 2^(2*WIDTH+1)*(SETTLE+2) cycles.
//   Conflicts:
//   - start while busy is ignored.
//   - rst has priority over start.
// TESTING
//   1 Correct CLA attached, SETTLE=1 -> done after 1536 cycles;
//     pass=1, err_count=0, fail_vld=0.
//   2 Adder model with sum[0] stuck-0 -> err_count=256;
//     first fail: a=0, b=1, cin=0; pass=0.
//   3 Adder model with cout stuck-0 -> err_count=256 (120 with cin=0, 136 with cin=1);
//     first fail: a=1, b=15, cin=0.
//   4 SETTLE=0, correct adder -> done after 1024 cycles, pass=1.
//   5 rst asserted at vector 100 mid-sweep -> next cycle all outputs 0, state IDLE;
//     new start runs the full sweep, pass=1.
//   6 start pulsed while busy -> no effect, done timing unchanged.
//     start pulsed in DONE -> counters cleared, sweep reruns.

Source files
------------

// File: rtl/cla_adder_bist.sv
// Exhaustive self-test sequencer for a WIDTH-bit combinational adder.
// Walks every {cin,a,b} vector, waits SETTLE cycles, then checks {cout,sum}
// against a+b+cin, counting mismatches and capturing the first failure.
module cla_adder_bist #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERRW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic             fail_vld,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin
);

    localparam int unsigned VW          = 2 * WIDTH + 1;
    localparam int unsigned RW          = WIDTH + 1;
    localparam int unsigned CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [VW-1:0]     vec_q, vec_d;
    logic [RW-1:0]     exp_q, exp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERRW-1:0]   err_q, err_d;
    logic              fail_vld_q, fail_vld_d;
    logic [VW-1:0]     fail_vec_q, fail_vec_d;
    logic              mism_c;

    // Adder response differs from the expected result latched in DRIVE
    assign mism_c = ({cout, sum} != exp_q);

    // Next-state and datapath updates for the sweep sequencer
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = '0;
                    err_d      = '0;
                    fail_vld_d = 1'b0;
                    fail_vec_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            ST_DRIVE: begin
                exp_d   = RW'(vec_q[2*WIDTH-1:WIDTH]) + RW'(vec_q[WIDTH-1:0]) + RW'(vec_q[VW-1]);
                cnt_d   = '0;
                state_d = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
            end
            ST_WAIT: begin
                if (cnt_q == CW'(SETTLE_LAST)) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CHECK: begin
                if (mism_c) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERRW'(1);
                    end
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_vec_d = vec_q;
                    end
                end
                if (vec_q == '1) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + VW'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign a         = vec_q[2*WIDTH-1:WIDTH];
    assign b         = vec_q[WIDTH-1:0];
    assign cin       = vec_q[VW-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vld  = fail_vld_q;
    assign fail_a    = fail_vec_q[2*WIDTH-1:WIDTH];
    assign fail_b    = fail_vec_q[WIDTH-1:0];
    assign fail_cin  = fail_vec_q[VW-1];

endmodule

// File: tb/tb_cla_adder_bist.sv
// Bench for cla_adder_bist: two instances (SETTLE=1/ERRW=16 and SETTLE=0/ERRW=4)
// driving a bench adder with selectable faults, checked every cycle against a
// timing/arithmetic model of the sweep.
module tb_cla_adder_bist;

    localparam int N  = 512;
    localparam int P0 = 3;
    localparam int P1 = 2;

    logic clk = 1'b0;
    logic rst, start;
    int          mode;
    int unsigned seed;

    logic [3:0]  a0, b0, sum0, fa0, fb0;
    logic        cin0, cout0, busy0, done0, pass0, fv0, fc0;
    logic [15:0] err0;
    logic [3:0]  a1, b1, sum1, fa1, fb1;
    logic        cin1, cout1, busy1, done1, pass1, fv1, fc1;
    logic [3:0]  err1;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m0_s, m1_s;
    int          m0_j, m1_j, m0_mode, m1_mode;
    int unsigned m0_seed, m1_seed;

    always #5 clk = ~clk;

    // Bench adder: ideal sum with an optional fault injected
    function automatic logic [4:0] adder_fn(input logic [8:0] v, input int md, input int unsigned sd);
        logic [4:0]  o;
        int unsigned h;
        o = 5'(int'(v[7:4]) + int'(v[3:0]) + int'(v[8]));
        h = (32'(v) * sd) >> 2;
        case (md)
            1: o[0] = 1'b0;
            2: o[4] = 1'b0;
            3: if (h % 5 == 0) o = o ^ 5'(1 << (int'(v) % 5));
            default: ;
        endcase
        return o;
    endfunction

    function automatic bit is_bad(input int v, input int md, input int unsigned sd);
        int ref_sum;
        ref_sum = ((v >> 4) & 15) + (v & 15) + ((v >> 8) & 1);
        return adder_fn(9'(v), md, sd) != 5'(ref_sum);
    endfunction

    // Expected outputs j edges after the accepting edge
    function automatic logic [37:0] expect_out(input bit st, input int j, input int md,
                                               input int unsigned sd, input int settle, input int errw);
        int p, nchk, cnt, first, sat;
        bit bsy;
        logic [8:0] vv, fvv;
        if (!st) return '0;
        p    = settle + 2;
        nchk = j / p;
        if (nchk > N) nchk = N;
        bsy  = (j < N * p);
        vv   = bsy ? 9'(j / p) : 9'(N - 1);
        cnt  = 0;
        first = -1;
        for (int x = 0; x < nchk; x++) begin
            if (is_bad(x, md, sd)) begin
                cnt++;
                if (first < 0) first = x;
            end
        end
        sat = (1 << errw) - 1;
        if (cnt > sat) cnt = sat;
        fvv = (first >= 0) ? 9'(first) : 9'(0);
        return {vv[7:4], vv[3:0], vv[8], bsy, !bsy, (!bsy && cnt == 0), 16'(cnt),
                (first >= 0), fvv[7:4], fvv[3:0], fvv[8]};
    endfunction

    assign {cout0, sum0} = adder_fn({cin0, a0, b0}, mode, seed);
    assign {cout1, sum1} = adder_fn({cin1, a1, b1}, mode, seed);

    cla_adder_bist #(.WIDTH(4), .SETTLE(1), .ERRW(16)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .a(a0), .b(b0), .cin(cin0), .sum(sum0), .cout(cout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vld(fv0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fc0)
    );

    cla_adder_bist #(.WIDTH(4), .SETTLE(0), .ERRW(4)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vld(fv1), .fail_a(fa1), .fail_b(fb1), .fail_cin(fc1)
    );

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs present at that edge
    task automatic step_model();
        if (rst) begin
            m0_s = 0; m0_j = 0; m1_s = 0; m1_j = 0;
        end else begin
            if (start && !(m0_s && m0_j < N * P0)) begin
                m0_s = 1; m0_j = 0; m0_mode = mode; m0_seed = seed;
            end else if (m0_s) m0_j++;
            if (start && !(m1_s && m1_j < N * P1)) begin
                m1_s = 1; m1_j = 0; m1_mode = mode; m1_seed = seed;
            end else if (m1_s) m1_j++;
        end
    endtask

    // Per-cycle comparison of both instances against the model
    task automatic compare();
        logic [37:0] e0, e1, g0, g1;
        e0 = expect_out(m0_s, m0_j, m0_mode, m0_seed, 1, 16);
        e1 = expect_out(m1_s, m1_j, m1_mode, m1_seed, 0, 4);
        g0 = {a0, b0, cin0, busy0, done0, pass0, err0, fv0, fa0, fb0, fc0};
        g1 = {a1, b1, cin1, busy1, done1, pass1, 16'(err1), fv1, fa1, fb1, fc1};
        n_cmp += 2;
        if (g0 !== e0) begin
            n_bad++;
            $display("FAIL u0_cycle t=%0t got=%h expected=%h", $time, g0, e0);
        end
        if (g1 !== e1) begin
            n_bad++;
            $display("FAIL u1_cycle t=%0t got=%h expected=%h", $time, g1, e1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step_model();
        @(negedge clk);
        compare();
    endtask

    task automatic run_sweep(input int md, input int unsigned sd, input int poke,
                             output int c0, output int c1);
        mode = md; seed = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_err", int'(err0), 0);
        check("start_sets_busy", int'(busy0), 1);
        c0 = 0; c1 = 0;
        while (done0 !== 1'b1 && c0 < 3000) begin
            start = (c0 == poke);
            tick();
            start = 1'b0;
            c0++;
            if (done1 === 1'b1 && c1 == 0) c1 = c0;
        end
        check("done0_reached", int'(done0), 1);
        for (int k = 0; k < 1100 && done1 !== 1'b1; k++) tick();
    endtask

    initial begin
        int c0, c1;
        m0_s = 0; m1_s = 0; m0_j = 0; m1_j = 0;
        m0_mode = 0; m1_mode = 0; m0_seed = 0; m1_seed = 0;
        rst = 1'b1; start = 1'b0; mode = 0; seed = 0;
        @(negedge clk);
        tick(); tick();
        check("rst_busy", int'(busy0), 0);
        check("rst_err", int'(err0), 0);
        rst = 1'b0;
        tick();

        // Healthy adder
        run_sweep(0, 0, -1, c0, c1);
        check("lat_settle1", c0, 1536);
        check("lat_settle0", c1, 1024);
        check("pass_ok", int'(pass0), 1);
        check("err_ok", int'(err0), 0);
        check("fail_vld_ok", int'(fv0), 0);
        check("pass_ok_s0", int'(pass1), 1);

        // sum[0] stuck at 0
        run_sweep(1, 0, -1, c0, c1);
        check("s0_err", int'(err0), 256);
        check("s0_fail_a", int'(fa0), 0);
        check("s0_fail_b", int'(fb0), 1);
        check("s0_fail_cin", int'(fc0), 0);
        check("s0_pass", int'(pass0), 0);
        check("s0_err_sat4", int'(err1), 15);

        // cout stuck at 0
        run_sweep(2, 0, -1, c0, c1);
        check("co_err", int'(err0), 256);
        check("co_fail_a", int'(fa0), 1);
        check("co_fail_b", int'(fb0), 15);
        check("co_fail_cin", int'(fc0), 0);

        // Reset mid-sweep at vector 100
        mode = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 100 * P0; k++) tick();
        check("pre_rst_vec", {23'(0), cin0, a0, b0}, 100);
        rst = 1'b1; tick(); rst = 1'b0;
        check("post_rst_busy", int'(busy0), 0);
        check("post_rst_a", int'(a0), 0);
        check("post_rst_b", int'(b0), 0);
        tick();
        run_sweep(0, 0, -1, c0, c1);
        check("after_rst_pass", int'(pass0), 1);

        // start while busy is ignored
        run_sweep(0, 0, 200, c0, c1);
        check("busy_start_lat", c0, 1536);

        // Randomized faults, stray starts and restarts from DONE
        for (int r = 0; r < 4; r++) begin
            run_sweep(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(900, 1500)), c0, c1);
            check("rand_lat", c0, 1536);
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
